// File: rtl/param_rr_router.sv
// Parameterised flit router: per-input FIFOs, table-driven routing, one
// round-robin arbiter and output register per port, windowed activity counter.
module param_rr_router #(
    parameter int NPORTS = 5,
    parameter int FLIT_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH = 4,
    parameter logic [3*(2**ADDR_W)-1:0] ROUTE_TABLE = '0,
    parameter int SAMPLE_W = 10,
    parameter int CNT_W = 20
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NPORTS-1:0]          in_valid,
    output logic [NPORTS-1:0]          in_ready,
    input  logic [NPORTS*FLIT_W-1:0]   in_data,
    output logic [NPORTS-1:0]          out_valid,
    input  logic [NPORTS-1:0]          out_ready,
    output logic [NPORTS*FLIT_W-1:0]   out_data,
    output logic [CNT_W-1:0]           flit_count,
    output logic                       count_update,
    output logic [NPORTS-1:0]          drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(NPORTS);
    localparam int SUM_W = CNT_W + 4;
    localparam logic [3:0] NP = 4'(NPORTS);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [FLIT_W-1:0] mem [NPORTS][DEPTH];
    logic [AW-1:0]     wr_ptr [NPORTS];
    logic [AW-1:0]     rd_ptr [NPORTS];
    logic [AW:0]       occ [NPORTS];
    logic [FLIT_W-1:0] head [NPORTS];
    logic [2:0]        route [NPORTS];
    logic [PW-1:0]     rr_ptr [NPORTS];
    logic [PW-1:0]     winner [NPORTS];
    logic [NPORTS-1:0] push, pop, head_ok, granted, any_gnt;

    logic [3:0]          accepts;
    logic [SUM_W-1:0]    sum;
    logic [CNT_W-1:0]    total, running;
    logic [SAMPLE_W-1:0] win_cnt;

    // Head decode; an illegal route is discarded in the cycle it is seen.
    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            head[p]     = mem[p][rd_ptr[p]];
            route[p]    = ROUTE_TABLE[int'(head[p][ADDR_W-1:0]) * 3 +: 3];
            in_ready[p] = (occ[p] != FULL);
            push[p]     = in_valid[p] & in_ready[p];
            head_ok[p]  = (occ[p] != '0) && ({1'b0, route[p]} < NP);
            drop[p]     = (occ[p] != '0) && !({1'b0, route[p]} < NP);
        end
    end

    always_comb begin
        int idx;
        idx = 0;
        granted = '0;
        any_gnt = '0;
        for (int o = 0; o < NPORTS; o++) begin
            winner[o] = '0;
            for (int k = 0; k < NPORTS; k++) begin
                idx = int'(rr_ptr[o]) + k;
                if (idx >= NPORTS) idx = idx - NPORTS;
                if ((!out_valid[o] || out_ready[o]) && !any_gnt[o] &&
                    head_ok[idx] && route[idx] == 3'(o)) begin
                    any_gnt[o] = 1'b1;
                    winner[o]  = PW'(idx);
                end
            end
            if (any_gnt[o]) granted[winner[o]] = 1'b1;
        end
    end

    assign pop = granted | drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NPORTS; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                occ[p]    <= '0;
            end
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                if (push[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
                if (pop[p])  rd_ptr[p] <= rd_ptr[p] + 1'b1;
                case ({push[p], pop[p]})
                    2'b10:   occ[p] <= occ[p] + 1'b1;
                    2'b01:   occ[p] <= occ[p] - 1'b1;
                    default: occ[p] <= occ[p];
                endcase
            end
        end
    end

    // Flit storage needs no reset; validity lives in the pointers.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NPORTS; p++)
            if (push[p]) mem[p][wr_ptr[p]] <= in_data[p*FLIT_W +: FLIT_W];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= '0;
            out_data  <= '0;
            for (int o = 0; o < NPORTS; o++) rr_ptr[o] <= '0;
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                if (any_gnt[o]) begin
                    out_valid[o] <= 1'b1;
                    out_data[o*FLIT_W +: FLIT_W] <= head[winner[o]];
                    rr_ptr[o] <= (winner[o] == PW'(NPORTS - 1)) ? '0 : winner[o] + 1'b1;
                end else if (out_ready[o]) begin
                    out_valid[o] <= 1'b0;
                end
            end
        end
    end

    // Running total includes the current cycle so last-cycle flits are kept.
    always_comb begin
        accepts = '0;
        for (int p = 0; p < NPORTS; p++) accepts = accepts + 4'(push[p]);
        sum   = SUM_W'(running) + SUM_W'(accepts);
        total = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt      <= '0;
            running      <= '0;
            flit_count   <= '0;
            count_update <= 1'b0;
        end else begin
            win_cnt      <= win_cnt + 1'b1;
            count_update <= &win_cnt;
            if (&win_cnt) begin
                flit_count <= total;
                running    <= '0;
            end else begin
                running <= total;
            end
        end
    end
endmodule

// File: tb/tb_param_rr_router.sv
// Randomised and directed bench for param_rr_router with a per-flow scoreboard
// and a window-count model derived from the routing and activity rules.
module tb_param_rr_router;
    localparam int NP = 5;
    localparam int FW = 32;
    localparam int CMAX = 31;

    // Addresses 0..12 map to (a+3)%5; 13..15 map to illegal ports 5,6,7.
    function automatic int route_of(int dest);
        return (dest < 13) ? (dest + 3) % 5 : dest - 8;
    endfunction

    function automatic logic [47:0] make_rt();
        logic [47:0] t;
        t = '0;
        for (int a = 0; a < 16; a++) t[a*3 +: 3] = 3'(route_of(a));
        return t;
    endfunction

    localparam logic [47:0] RT = make_rt();

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NP-1:0] in_valid = '0, in_ready, out_valid, out_ready = '1, drop;
    logic [NP*FW-1:0] in_data = '0, out_data;
    logic [4:0]    flit_count;
    logic          count_update;

    param_rr_router #(.NPORTS(NP), .FLIT_W(FW), .ADDR_W(4), .DEPTH(4),
                      .ROUTE_TABLE(RT), .SAMPLE_W(3), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .flit_count(flit_count),
        .count_update(count_update), .drop(drop));

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    logic [23:0] seq_ctr = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int p, input int dest);
        seq_ctr = seq_ctr + 1'b1;
        in_data[p*FW +: FW] = {seq_ctr, 4'(p), 4'(dest)};
        in_valid[p] = 1'b1;
    endtask

    // Reference model: per (source,output) in-order queues, drop tallies, window sums.
    logic [31:0] sb [NP*NP][$];
    int exp_drop [NP];
    int got_drop [NP];
    int win_m = 0, acc_m = 0, exp_fc = 0;
    bit exp_upd = 0;

    always @(negedge clk) begin
        int n, r, s;
        logic [31:0] d;
        if (reset) begin
            for (int i = 0; i < NP*NP; i++) sb[i].delete();
            for (int p = 0; p < NP; p++) begin exp_drop[p] = 0; got_drop[p] = 0; end
            win_m = 0; acc_m = 0; exp_upd = 0;
        end else begin
            chk("count_update", count_update, exp_upd);
            if (exp_upd) chk("flit_count", flit_count, exp_fc);
            n = 0;
            for (int p = 0; p < NP; p++) begin
                if (in_valid[p] && in_ready[p]) begin
                    n++;
                    d = in_data[p*FW +: FW];
                    r = route_of(int'(d[3:0]));
                    if (r >= NP) exp_drop[p]++;
                    else sb[p*NP + r].push_back(d);
                end
                if (drop[p]) got_drop[p]++;
            end
            for (int o = 0; o < NP; o++) begin
                if (out_valid[o] && out_ready[o]) begin
                    d = out_data[o*FW +: FW];
                    s = int'(d[7:4]);
                    if (s < NP && sb[s*NP + o].size() > 0) chk("sb_data", d, sb[s*NP + o].pop_front());
                    else chk("sb_unexpected", d, 64'hdead);
                end
            end
            if (win_m == 7) begin
                exp_upd = 1;
                exp_fc = (acc_m + n > CMAX) ? CMAX : acc_m + n;
                acc_m = 0;
            end else begin
                exp_upd = 0;
                acc_m = acc_m + n;
            end
            win_m = (win_m + 1) % 8;
        end
    end

    initial begin
        logic [31:0] first, cur;
        logic [NP-1:0] acc_v;
        int n_acc, ng, nd;
        bit any_ov;

        // Reset state
        step(); step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_flit_count", flit_count, 0);
        chk("rst_count_update", count_update, 0);
        chk("rst_drop", drop, 0);
        reset = 1'b0;
        step();
        chk("rst_in_ready", in_ready, 5'h1f);

        // Minimum latency, dest 3 -> output 1
        put(0, 3);
        cur = in_data[31:0];
        step();
        in_valid = '0;
        chk("lat_edge_k", out_valid, 0);
        step();
        chk("lat_edge_k1", out_valid, 5'b00010);
        chk("lat_data", out_data[63:32], cur);
        step(); step();

        // Backpressure on output 1
        out_ready = 5'b11101;
        n_acc = 0;
        first = '0;
        put(0, 3);
        for (int i = 0; i < 10; i++) begin
            cur = in_data[31:0];
            acc_v[0] = in_ready[0];
            step();
            if (acc_v[0]) begin
                n_acc++;
                if (n_acc == 1) first = cur;
                put(0, 3);
            end
        end
        in_valid = '0;
        chk("bp_accepts", n_acc, 5);
        chk("bp_in_ready", in_ready[0], 0);
        chk("bp_hold_valid", out_valid[1], 1);
        chk("bp_hold_data", out_data[63:32], first);
        out_ready = '1;
        for (int i = 0; i < 8; i++) step();
        chk("bp_drained_v", out_valid[1], 0);
        chk("bp_drained_rdy", in_ready[0], 1);

        // Illegal route (entry 15 -> 7) on port 2
        nd = 0;
        any_ov = 0;
        put(2, 15);
        for (int i = 0; i < 8; i++) begin
            step();
            if (i < 2) put(2, 15); else in_valid = '0;
            if (drop[2]) nd++;
            if (out_valid != 0) any_ov = 1;
        end
        chk("drop_pulses", nd, 3);
        chk("drop_no_out", any_ov, 0);
        chk("drop_fifo_empty", in_ready[2], 1);

        // Reset mid-operation with buffered flits and valid outputs
        out_ready = '0;
        for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < NP; p++) put(p, (p + 2) % 5);
            step();
        end
        in_valid = '0;
        step();
        chk("pre_rst_valid", out_valid, 5'h1f);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data[63:0], 0);
        chk("mid_rst_drop", drop, 0);
        chk("mid_rst_fc", flit_count, 0);
        step();
        reset = 1'b0;
        out_ready = '1;
        step();
        chk("post_rst_ready", in_ready, 5'h1f);
        chk("post_rst_valid", out_valid, 0);

        // Round robin 0,2,4 into output 1, starting from input 0
        ng = 0;
        for (int p = 0; p < NP; p += 2) put(p, 3);
        for (int c = 0; c < 30; c++) begin
            acc_v = in_valid & in_ready;
            step();
            for (int p = 0; p < NP; p += 2) begin
                if (c >= 11) in_valid[p] = 1'b0;
                else if (acc_v[p]) put(p, 3);
            end
            if (out_valid[1] && ng < 9) begin
                chk("rr_order", out_data[39:36], (ng % 3) * 2);
                ng++;
            end
        end
        chk("rr_grants", ng, 9);

        // Activity windows: 2/cycle for 8 cycles, then 5/cycle saturates
        reset = 1'b1;
        step();
        reset = 1'b0;
        put(0, 2); put(1, 3);
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i < 8) begin put(0, 2); put(1, 3); end
            else if (i < 16) for (int p = 0; p < NP; p++) put(p, (p + 2) % 5);
            else in_valid = '0;
            chk("win_pulse", count_update, (i == 8 || i == 16));
            if (i == 8) chk("win_count16", flit_count, 16);
            if (i == 16) chk("win_saturate", flit_count, CMAX);
        end

        // Random traffic against the scoreboard
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < NP; p++) begin
                seq_ctr = seq_ctr + 1'b1;
                in_data[p*FW +: FW] = {seq_ctr, 4'(p), 4'($urandom_range(0, 15))};
            end
            in_valid = NP'($urandom);
            for (int o = 0; o < NP; o++) out_ready[o] = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = '0;
        out_ready = '1;
        for (int i = 0; i < 30; i++) step();
        for (int i = 0; i < NP*NP; i++) chk("sb_leftover", sb[i].size(), 0);
        for (int p = 0; p < NP; p++) chk("drop_total", got_drop[p], exp_drop[p]);
        chk("final_idle", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
